// File: rtl/bit_packer_if.sv
// Handshake bundle between the code concatenator, the bit packer and the
// downstream word consumer.
interface bit_packer_if #(
  parameter int TOTAL_BITS = 34,
  parameter int OUT_WIDTH  = 64
);
  localparam int VB_W = $clog2(OUT_WIDTH) + 1;

  logic                  i_valid;
  logic                  o_ready;
  logic [2:0]            i_code;
  logic [TOTAL_BITS-1:0] i_compressed_word;
  logic                  i_flush;
  logic                  o_valid;
  logic                  i_ready;
  logic [OUT_WIDTH-1:0]  o_data;
  logic                  o_last;
  logic [VB_W-1:0]       o_valid_bits;
  logic                  o_busy;
  logic                  o_code_err;

  modport master (
    output i_valid, i_code, i_compressed_word, i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_valid_bits, o_busy, o_code_err
  );

  modport slave (
    input  i_valid, i_code, i_compressed_word, i_flush, i_ready,
    output o_ready, o_valid, o_data, o_last, o_valid_bits, o_busy, o_code_err
  );
endinterface

// File: rtl/bit_packer.sv
// Packs variable-length compressed codes LSB-first into OUT_WIDTH-bit words;
// a flush drains the residue as a zero-padded final word with its bit count.
module bit_packer #(
  parameter int TOTAL_BITS = 34,
  parameter int OUT_WIDTH  = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  bit_packer_if.slave  bus
);
  localparam int BUF_W  = OUT_WIDTH + TOTAL_BITS;
  localparam int FILL_W = $clog2(BUF_W);
  localparam int LEN_W  = $clog2(TOTAL_BITS + 1);
  localparam int VB_W   = $clog2(OUT_WIDTH) + 1;

  typedef enum logic {PACK, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               code_err_q, code_err_d;

  logic [LEN_W-1:0]      code_len;
  logic                  code_illegal;
  logic [TOTAL_BITS-1:0] code_masked;
  logic [OUT_WIDTH-1:0]  tail_mask;
  logic                  full_word;
  logic                  out_valid, out_ready, out_last, out_busy;
  logic [OUT_WIDTH-1:0]  out_data;
  logic [VB_W-1:0]       out_vbits;
  logic                  accept, pop;
  logic [BUF_W-1:0]      buf_pop;
  logic [FILL_W-1:0]     fill_pop;

  always_comb begin
    code_len     = '0;
    code_illegal = 1'b0;
    case (bus.i_code)
      3'b000:  code_len = LEN_W'(2);
      3'b001:  code_len = LEN_W'(6);
      3'b010:  code_len = LEN_W'(12);
      3'b011:  code_len = LEN_W'(16);
      3'b100:  code_len = LEN_W'(24);
      3'b101:  code_len = LEN_W'(TOTAL_BITS);
      default: code_illegal = 1'b1;
    endcase
  end

  // Upper code bits and unfilled output bits are forced to zero.
  generate
    for (genvar gi = 0; gi < TOTAL_BITS; gi++) begin : g_code_mask
      assign code_masked[gi] = bus.i_compressed_word[gi] & (code_len > LEN_W'(gi));
    end
    for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_tail_mask
      assign tail_mask[gi] = (fill_q > FILL_W'(gi));
    end
  endgenerate

  assign full_word = (fill_q >= FILL_W'(OUT_WIDTH));

  always_comb begin
    state_d   = state_q;
    out_valid = full_word;
    out_ready = ~full_word | bus.i_ready;
    out_data  = buf_q[OUT_WIDTH-1:0];
    out_vbits = VB_W'(OUT_WIDTH);
    out_last  = 1'b0;
    out_busy  = 1'b0;
    case (state_q)
      PACK: begin
        if (bus.i_flush) state_d = FLUSH;
      end
      FLUSH: begin
        out_ready = 1'b0;
        out_busy  = 1'b1;
        if (!full_word) begin
          out_valid = 1'b1;
          out_data  = buf_q[OUT_WIDTH-1:0] & tail_mask;
          out_vbits = VB_W'(fill_q);
          out_last  = 1'b1;
          if (bus.i_ready) state_d = PACK;
        end
      end
      default: state_d = PACK;
    endcase
  end

  assign accept = bus.i_valid & out_ready;
  assign pop    = out_valid & bus.i_ready;

  // A code accepted alongside a pop lands at the post-pop fill position.
  always_comb begin
    buf_pop  = buf_q;
    fill_pop = fill_q;
    if (pop) begin
      if (out_last) begin
        buf_pop  = '0;
        fill_pop = '0;
      end else begin
        buf_pop  = buf_q >> OUT_WIDTH;
        fill_pop = fill_q - FILL_W'(OUT_WIDTH);
      end
    end
    buf_d      = buf_pop;
    fill_d     = fill_pop;
    code_err_d = code_err_q;
    if (accept) begin
      buf_d  = buf_pop | (BUF_W'(code_masked) << fill_pop);
      fill_d = fill_pop + FILL_W'(code_len);
      if (code_illegal) code_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= PACK;
      buf_q      <= '0;
      fill_q     <= '0;
      code_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      code_err_q <= code_err_d;
    end
  end

  assign bus.o_valid      = out_valid;
  assign bus.o_ready      = out_ready;
  assign bus.o_data       = out_data;
  assign bus.o_last       = out_last;
  assign bus.o_valid_bits = out_vbits;
  assign bus.o_busy       = out_busy;
  assign bus.o_code_err   = code_err_q;
endmodule
